adder_share_arbiter: RTL and testbench

//  Shares one 8-bit add/subtract unit between NREQ requesters.

---
 rtl/adder_share_pkg.sv | 14 +
 rtl/shared_addsub_unit.sv | 25 ++
 rtl/adder_share_arbiter.sv | 135 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and default sizing for the adder-sharing arbiter block.
package adder_share_pkg;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 8;
   localparam int IDW_DEF   = $clog2(NREQ_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/shared_addsub_unit.sv
// Combinational add/subtract unit shared by all requesters.
// Subtraction is A + ~B + 1, so cout=1 means "no borrow".
module shared_addsub_unit
   import adder_share_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);

   logic [WIDTH-1:0] b_eff;

   always_comb begin
      b_eff           = sub_i ? ~b_i : b_i;
      {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};
      // Signed overflow: operands agree in sign, result disagrees.
      ovf_o           = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one add/sub unit between NREQ requesters.
// Handshakes: a transfer happens in any cycle where valid and ready are both 1 at the rising edge.
module adder_share_arbiter
   import adder_share_pkg::*;
#(
   parameter  int NREQ  = NREQ_DEF,
   parameter  int WIDTH = WIDTH_DEF,
   localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_sub,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_cout,
   output logic                  rsp_ovf,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy,
   output state_t                dbg_state
);

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q;
   logic [IDW-1:0]   id_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             sub_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q;

   logic [IDW-1:0]   winner;
   logic             any_valid;
   logic             accept;
   logic [IDW-1:0]   next_ptr;
   logic [WIDTH-1:0] unit_sum;
   logic             unit_cout, unit_ovf;

   // First valid requester starting at ptr and walking upward with wrap.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [IDW-1:0]  ptr);
      logic [IDW-1:0] pick;
      logic [IDW-1:0] k;
      logic           found;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         k = IDW'((int'(ptr) + i) % NREQ);
         if (!found && v[k]) begin
            pick  = k;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign any_valid = |req_valid;
   assign winner    = rr_pick(req_valid, rr_ptr_q);
   assign accept    = (state_q == IDLE) && any_valid;
   assign next_ptr  = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

   shared_addsub_unit #(
      .WIDTH (WIDTH)
   ) u_unit (
      .a_i    (a_q),
      .b_i    (b_q),
      .sub_i  (sub_q),
      .sum_o  (unit_sum),
      .cout_o (unit_cout),
      .ovf_o  (unit_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_valid) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready[id_q]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (state_q == IDLE && any_valid) req_ready[winner] = 1'b1;
      if (state_q == RESP)              rsp_valid[id_q]   = 1'b1;
      busy      = (state_q != IDLE);
   end

   // Operands are latched at accept so requesters may change inputs afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (accept) begin
            id_q  <= winner;
            a_q   <= req_a[int'(winner)*WIDTH +: WIDTH];
            b_q   <= req_b[int'(winner)*WIDTH +: WIDTH];
            sub_q <= req_sub[winner];
         end
         if (state_q == EXEC) begin
            sum_q    <= unit_sum;
            cout_q   <= unit_cout;
            ovf_q    <= unit_ovf;
            rr_ptr_q <= next_ptr;
         end
      end
   end

   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign rsp_ovf   = ovf_q;
   assign grant_id  = id_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (NREQ=4, WIDTH=8).
module tb_adder_share_arbiter;
   import adder_share_pkg::*;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
   logic [NREQ*W-1:0] req_a, req_b;
   logic [W-1:0]    rsp_sum;
   logic            rsp_cout, rsp_ovf, busy;
   logic [1:0]      grant_id;
   state_t          dbg_state;

   int checks   = 0;
   int failures = 0;

   adder_share_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_ovf   (rsp_ovf),
      .grant_id  (grant_id),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one op and returns what was observed at accept+1 and accept+2.
   task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, output logic acc_ok,
                         output logic [NREQ-1:0] v1, output logic [NREQ-1:0] v2,
                         output logic [W-1:0] s, output logic c, output logic o,
                         output logic [1:0] gid);
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
      req_sub[id]      = sub;
      req_valid[id]    = 1'b1;
      #1;
      acc_ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (req_ready[id]) begin
            acc_ok = 1'b1;
            break;
         end
         tick();
      end
      v1 = '0; v2 = '0; s = '0; c = 1'b0; o = 1'b0; gid = '0;
      if (!acc_ok) begin
         req_valid[id] = 1'b0;
         return;
      end
      tick();
      req_valid[id]    = 1'b0;
      req_a[id*W +: W] = 8'h5A;
      req_b[id*W +: W] = 8'hC3;
      req_sub[id]      = ~sub;
      v1 = rsp_valid;
      tick();
      v2 = rsp_valid; s = rsp_sum; c = rsp_cout; o = rsp_ovf; gid = grant_id;
      rsp_ready[id] = 1'b1;
      tick();
      rsp_ready[id] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b required 0000", req_ready); end
      checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid: got %b required 0000", rsp_valid); end
      checks++; if ({rsp_sum, rsp_cout, rsp_ovf} !== 10'd0) begin failures++; $display("FAIL reset_result: got %h/%b/%b required 00/0/0", rsp_sum, rsp_cout, rsp_ovf); end
      checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id: got %0d required 0", grant_id); end
      checks++; if (busy !== 1'b0 || dbg_state !== IDLE) begin failures++; $display("FAIL reset_state: got busy=%b state=%0d required 0/IDLE", busy, dbg_state); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_add();
      logic ok, c, o;
      logic [NREQ-1:0] v1, v2;
      logic [W-1:0] s;
      logic [1:0] gid;
      run_op(0, 8'h01, 8'h01, 1'b0, ok, v1, v2, s, c, o, gid);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL add_accept: got %b required 1", ok); end
      checks++; if (v1 !== 4'b0000) begin failures++; $display("FAIL add_lat_t1: got %b required 0000", v1); end
      checks++; if (v2 !== 4'b0001) begin failures++; $display("FAIL add_lat_t2: got %b required 0001", v2); end
      checks++; if ({s, c, o} !== {8'h02, 1'b0, 1'b0}) begin failures++; $display("FAIL add_result: got %h/%b/%b required 02/0/0", s, c, o); end
      checks++; if (gid !== 2'd0) begin failures++; $display("FAIL add_grant: got %0d required 0", gid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_idle_after: got %b required 0", busy); end
   endtask

   task automatic test_carry_sub();
      logic [W-1:0] ta[2] = '{8'hFF, 8'h05};
      logic [W-1:0] tb[2] = '{8'h01, 8'h07};
      logic         tsub[2] = '{1'b0, 1'b1};
      logic [W-1:0] es[2] = '{8'h00, 8'hFE};
      logic         ec[2] = '{1'b1, 1'b0};
      logic ok, c, o;
      logic [NREQ-1:0] v1, v2;
      logic [W-1:0] s;
      logic [1:0] gid;
      for (int i = 0; i < 2; i++) begin
         run_op(1, ta[i], tb[i], tsub[i], ok, v1, v2, s, c, o, gid);
         checks++; if (ok !== 1'b1 || v2 !== 4'b0010) begin failures++; $display("FAIL carry_sub_valid[%0d]: got ok=%b v=%b required 1/0010", i, ok, v2); end
         checks++; if ({s, c, o} !== {es[i], ec[i], 1'b0}) begin failures++; $display("FAIL carry_sub_result[%0d]: got %h/%b/%b required %h/%b/0", i, s, c, o, es[i], ec[i]); end
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] ta[2] = '{8'h80, 8'h7F};
      logic [W-1:0] tb[2] = '{8'h80, 8'h01};
      logic [W-1:0] es[2] = '{8'h00, 8'h80};
      logic         ec[2] = '{1'b1, 1'b0};
      logic ok, c, o;
      logic [NREQ-1:0] v1, v2;
      logic [W-1:0] s;
      logic [1:0] gid;
      for (int i = 0; i < 2; i++) begin
         run_op(2, ta[i], tb[i], 1'b0, ok, v1, v2, s, c, o, gid);
         checks++; if (ok !== 1'b1 || v2 !== 4'b0100) begin failures++; $display("FAIL ovf_valid[%0d]: got ok=%b v=%b required 1/0100", i, ok, v2); end
         checks++; if ({s, c, o} !== {es[i], ec[i], 1'b1}) begin failures++; $display("FAIL ovf_result[%0d]: got %h/%b/%b required %h/%b/1", i, s, c, o, es[i], ec[i]); end
      end
   endtask

   task automatic test_round_robin();
      logic [W-1:0] exp_sum[NREQ] = '{8'h02, 8'h30, 8'hFF, 8'h02};
      logic [1:0]   exp_q[$];
      logic [1:0]   exp_g;
      int           winner;
      logic         ok;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      req_a     = {8'h03, 8'hAA, 8'h10, 8'h01};
      req_b     = {8'h01, 8'h55, 8'h20, 8'h01};
      req_sub   = 4'b1000;
      req_valid = 4'b1111;
      #1;
      for (int n = 0; n < 5; n++) begin
         ok = 1'b0;
         for (int k = 0; k < 20; k++) begin
            if (req_ready !== 4'b0000) begin
               ok = 1'b1;
               break;
            end
            tick();
         end
         checks++; if (!ok) begin failures++; $display("FAIL rr_accept[%0d]: got no req_ready required grant", n); break; end
         winner = 0;
         for (int i = 0; i < NREQ; i++) if (req_ready[i]) winner = i;
         exp_g = exp_q.pop_front();
         checks++; if (!$onehot(req_ready)) begin failures++; $display("FAIL rr_onehot[%0d]: got %b required one-hot", n, req_ready); end
         checks++; if (winner !== int'(exp_g)) begin failures++; $display("FAIL rr_grant[%0d]: got %0d required %0d", n, winner, exp_g); end
         tick();
         tick();
         checks++; if (rsp_valid !== (4'b0001 << exp_g)) begin failures++; $display("FAIL rr_rsp_valid[%0d]: got %b required %b", n, rsp_valid, 4'b0001 << exp_g); end
         checks++; if (rsp_sum !== exp_sum[exp_g] || grant_id !== exp_g) begin failures++; $display("FAIL rr_result[%0d]: got sum=%h id=%0d required %h/%0d", n, rsp_sum, grant_id, exp_sum[exp_g], exp_g); end
         rsp_ready = 4'b0001 << exp_g;
         tick();
         rsp_ready = 4'b0000;
      end
      req_valid = 4'b0000;
      req_sub   = 4'b0000;
      tick();
   endtask

   task automatic test_backpressure();
      logic ok;
      req_a[3*W +: W] = 8'h80;
      req_b[3*W +: W] = 8'h01;
      req_sub[3]      = 1'b1;
      req_valid       = 4'b1000;
      #1;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (req_ready[3]) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      checks++; if (!ok) begin failures++; $display("FAIL bp_accept: got no req_ready[3] required 1"); end
      tick();
      req_valid = 4'b0111;
      rsp_ready = 4'b0111;
      tick();
      for (int n = 0; n < 5; n++) begin
         checks++; if (rsp_valid !== 4'b1000 || dbg_state !== RESP) begin failures++; $display("FAIL bp_hold_state[%0d]: got v=%b st=%0d required 1000/RESP", n, rsp_valid, dbg_state); end
         checks++; if ({rsp_sum, rsp_cout, rsp_ovf} !== {8'h7F, 1'b1, 1'b1}) begin failures++; $display("FAIL bp_hold_result[%0d]: got %h/%b/%b required 7F/1/1", n, rsp_sum, rsp_cout, rsp_ovf); end
         checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_req_ready[%0d]: got %b required 0000", n, req_ready); end
         tick();
      end
      req_valid = 4'b0000;
      rsp_ready = 4'b1000;
      tick();
      rsp_ready = 4'b0000;
      checks++; if (dbg_state !== IDLE || busy !== 1'b0 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL bp_release: got st=%0d busy=%b v=%b required IDLE/0/0000", dbg_state, busy, rsp_valid); end
      req_sub = 4'b0000;
   endtask

   task automatic test_reset_mid_op();
      logic ok, c, o;
      logic [NREQ-1:0] v1, v2;
      logic [W-1:0] s;
      logic [1:0] gid;
      run_op(1, 8'h20, 8'h22, 1'b0, ok, v1, v2, s, c, o, gid);
      checks++; if (ok !== 1'b1 || s !== 8'h42) begin failures++; $display("FAIL mid_pre_op: got ok=%b sum=%h required 1/42", ok, s); end
      req_a[2*W +: W] = 8'h11;
      req_b[2*W +: W] = 8'h11;
      req_valid       = 4'b0100;
      #1;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (req_ready[2]) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
      req_valid = 4'b0000;
      checks++; if (!ok || dbg_state !== EXEC) begin failures++; $display("FAIL mid_exec: got ok=%b st=%0d required 1/EXEC", ok, dbg_state); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0 || dbg_state !== IDLE) begin failures++; $display("FAIL mid_abort_state: got v=%b busy=%b st=%0d required 0000/0/IDLE", rsp_valid, busy, dbg_state); end
      checks++; if ({rsp_sum, rsp_cout, rsp_ovf, grant_id} !== 12'd0) begin failures++; $display("FAIL mid_abort_outputs: got %h/%b/%b id=%0d required 00/0/0 id=0", rsp_sum, rsp_cout, rsp_ovf, grant_id); end
      for (int n = 0; n < 4; n++) begin
         tick();
         checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL mid_no_rsp[%0d]: got %b required 0000", n, rsp_valid); end
      end
      req_valid = 4'b1001;
      #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_rr_ptr_reset: got %b required 0001", req_ready); end
      req_valid = 4'b0000;
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_sub   = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      tick();
      test_reset();
      test_single_add();
      test_carry_sub();
      test_overflow();
      test_round_robin();
      test_backpressure();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
